// File: rtl/timer_multi_pkg.sv
// Shared constants for the multi-channel AHB-lite timer: register offsets,
// CTRL bit positions and the per-channel address stride.
package timer_multi_pkg;

  // Register offsets within one channel's window
  localparam logic [3:0] OFF_CTRL  = 4'h0;
  localparam logic [3:0] OFF_LOAD  = 4'h4;
  localparam logic [3:0] OFF_VALUE = 4'h8;
  localparam logic [3:0] OFF_INT   = 4'hC;

  // Global prescaler register; everything at or above this is outside channel space
  localparam logic [8:0] OFF_PSC   = 9'h100;

  // Address distance between consecutive channels
  localparam logic [8:0] CH_STRIDE = 9'h010;
  localparam int unsigned CH_SHIFT = $clog2(CH_STRIDE);

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_IE      = 2;

  // Channel number selected by a byte address inside channel space
  function automatic logic [3:0] ch_index(input logic [8:0] byte_addr);
    return byte_addr[CH_SHIFT +: 4];
  endfunction

  // Register offset inside the selected channel's window
  function automatic logic [3:0] reg_offset(input logic [8:0] byte_addr);
    return byte_addr[CH_SHIFT-1:0];
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: CTRL (EN/ONESHOT/IE), LOAD, VALUE and a
// sticky INT flag, with register readback and a level interrupt output.
module timer_channel
  import timer_multi_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        wr_ctrl,
  input  logic        wr_load,
  input  logic        wr_int,
  input  logic [31:0] wdata,
  input  logic [3:0]  rd_sel,
  output logic [31:0] rdata,
  output logic        en,
  output logic        irq
);

  logic             oneshot;
  logic             ie;
  logic             flag;
  logic [CNT_W-1:0] load;
  logic [CNT_W-1:0] value;
  logic             terminal;

  assign terminal = tick && en && (value == '0);
  assign irq      = flag && ie;

  // Counting, bus writes and the sticky flag; later assignments take priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en      <= 1'b0;
      oneshot <= 1'b0;
      ie      <= 1'b0;
      flag    <= 1'b0;
      load    <= '0;
      value   <= '0;
    end else begin
      if (tick && en) begin
        if (value != '0) begin
          value <= value - CNT_W'(1);
        end else if (!oneshot) begin
          value <= load;
        end else begin
          en <= 1'b0;
        end
      end
      // LOAD write overrides any tick in the same cycle
      if (wr_load) begin
        load  <= wdata[CNT_W-1:0];
        value <= wdata[CNT_W-1:0];
      end
      // bus write wins over the hardware one-shot EN clear
      if (wr_ctrl) begin
        en      <= wdata[CTRL_EN];
        oneshot <= wdata[CTRL_ONESHOT];
        ie      <= wdata[CTRL_IE];
      end
      if (wr_int && wdata[0]) begin
        flag <= 1'b0;
      end
      // a new terminal event beats a simultaneous write-1-clear
      if (terminal) begin
        flag <= 1'b1;
      end
    end
  end

  // Register readback for the offset selected by the top level
  always_comb begin
    rdata = '0;
    unique case (rd_sel)
      OFF_CTRL: begin
        rdata[CTRL_EN]      = en;
        rdata[CTRL_ONESHOT] = oneshot;
        rdata[CTRL_IE]      = ie;
      end
      OFF_LOAD:  rdata[CNT_W-1:0] = load;
      OFF_VALUE: rdata[CNT_W-1:0] = value;
      OFF_INT:   rdata[0]         = flag;
      default:   rdata            = '0;
    endcase
  end

endmodule

// File: rtl/ahblite_timer_multi.sv
// AHB-lite slave with NUM_CH independent down-counting timers.
// Optional shared prescaler enabled by defining TIMER_PRESCALER_EN.
module ahblite_timer_multi
  import timer_multi_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [3:0]        HPROT,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic [1:0]        HRESP,
  output logic [NUM_CH-1:0] TimerIrq_o
);

  logic              trans_en;
  logic [6:0]        addr_q;
  logic              write_q;
  logic              read_q;
  logic [8:0]        byte_addr;
  logic              ch_space;
  logic [3:0]        ch_idx;
  logic [3:0]        reg_off;
  logic              wr_fire;
  logic              tick;
  logic [NUM_CH-1:0] en_vec;
  logic [31:0]       ch_rdata [NUM_CH];
  logic [31:0]       rdata;
  logic              unused_ok;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 2'b00;
  assign trans_en  = HSEL && HTRANS[1] && HREADY;

  // Address phase capture
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
    end else if (HREADY) begin
      addr_q  <= HADDR[8:2];
      write_q <= trans_en && HWRITE;
      read_q  <= trans_en && !HWRITE;
    end
  end

  assign byte_addr = {addr_q, 2'b00};
  assign ch_space  = byte_addr < OFF_PSC;
  assign ch_idx    = ch_index(byte_addr);
  assign reg_off   = reg_offset(byte_addr);
  assign wr_fire   = write_q && HREADY;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic hit;
    assign hit = wr_fire && ch_space && (ch_idx == 4'(g));

    timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (HCLK),
      .rst_n   (HRESETn),
      .tick    (tick),
      .wr_ctrl (hit && (reg_off == OFF_CTRL)),
      .wr_load (hit && (reg_off == OFF_LOAD)),
      .wr_int  (hit && (reg_off == OFF_INT)),
      .wdata   (HWDATA),
      .rd_sel  (reg_off),
      .rdata   (ch_rdata[g]),
      .en      (en_vec[g]),
      .irq     (TimerIrq_o[g])
    );
  end

`ifdef TIMER_PRESCALER_EN
  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_cnt;
  logic             any_en;
  logic             wr_psc;

  assign any_en = |en_vec;
  assign wr_psc = wr_fire && (byte_addr == OFF_PSC);
  assign tick   = any_en && (psc_cnt == psc);

  // Shared prescaler: counts 0..PSC while any channel is enabled
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      psc     <= '0;
      psc_cnt <= '0;
    end else if (wr_psc) begin
      psc     <= HWDATA[PSC_W-1:0];
      psc_cnt <= '0;
    end else if (any_en) begin
      psc_cnt <= (psc_cnt == psc) ? '0 : psc_cnt + PSC_W'(1);
    end
  end

  assign unused_ok = ^{HSIZE, HPROT, HADDR[31:9], HADDR[1:0], HTRANS[0]};
`else
  logic [PSC_W-1:0] unused_psc;

  assign tick       = 1'b1;
  assign unused_psc = '0;
  assign unused_ok  = ^{HSIZE, HPROT, HADDR[31:9], HADDR[1:0], HTRANS[0], en_vec};
`endif

  // Data-phase read mux; unmapped offsets and absent channels return 0
  always_comb begin
    rdata = '0;
    if (read_q) begin
      if (ch_space) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (ch_idx == 4'(i)) begin
            rdata = ch_rdata[i];
          end
        end
      end
`ifdef TIMER_PRESCALER_EN
      else if (byte_addr == OFF_PSC) begin
        rdata[PSC_W-1:0] = psc;
      end
`endif
    end
  end

  assign HRDATA = rdata;

endmodule

// File: tb/tb_ahblite_timer_multi.sv
// Directed self-checking bench for ahblite_timer_multi (NUM_CH=2, CNT_W=32).
module tb_ahblite_timer_multi;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;
  logic [1:0]  TimerIrq_o;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahblite_timer_multi #(
    .NUM_CH (2),
    .CNT_W  (32),
    .PSC_W  (16)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HSIZE      (HSIZE),
    .HPROT      (HPROT),
    .HWRITE     (HWRITE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HREADYOUT  (HREADYOUT),
    .HRDATA     (HRDATA),
    .HRESP      (HRESP),
    .TimerIrq_o (TimerIrq_o)
  );

  // Address phase in the current cycle; returns during the data phase with HWDATA driven
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
  endtask

  // Address phase in the current cycle; samples HRDATA during the data phase
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] a;
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    checks++;
    if (TimerIrq_o !== 2'b00) begin
      $display("FAIL reset_irq got %b want 00", TimerIrq_o); errors++;
    end
    checks++;
    if (HRDATA !== 32'h0) begin
      $display("FAIL reset_hrdata got %h want 00000000", HRDATA); errors++;
    end
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 2'b00) begin
      $display("FAIL bus_resp got hreadyout=%b hresp=%b want 1 00", HREADYOUT, HRESP); errors++;
    end
    for (int i = 0; i < 8; i++) begin
      a = 32'((i / 4) * 16 + (i % 4) * 4);
      bus_read(a, rd);
      checks++;
      if (rd !== 32'h0) begin
        $display("FAIL reset_reg addr=%h got %h want 00000000", a, rd); errors++;
      end
    end
  endtask

  task automatic test_periodic();
    logic [31:0] rd;
    logic [31:0] exp_v [5] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
    bus_write(32'h04, 32'd3);
    bus_write(32'h00, 32'h5);
    for (int i = 0; i < 5; i++) begin
      bus_read(32'h08, rd);
      checks++;
      if (rd !== exp_v[i]) begin
        $display("FAIL periodic_value[%0d] got %0d want %0d", i, rd, exp_v[i]); errors++;
      end
      checks++;
      if (TimerIrq_o[0] !== (i == 4)) begin
        $display("FAIL periodic_irq[%0d] got %b want %b", i, TimerIrq_o[0], (i == 4)); errors++;
      end
    end
    bus_read(32'h0C, rd);
    checks++;
    if (rd !== 32'h1) begin
      $display("FAIL periodic_int got %h want 1", rd); errors++;
    end
    bus_write(32'h0C, 32'h1);
    @(posedge HCLK); #1;
    checks++;
    if (TimerIrq_o[0] !== 1'b0) begin
      $display("FAIL periodic_clear got %b want 0", TimerIrq_o[0]); errors++;
    end
    @(posedge HCLK); #1;
    checks++;
    if (TimerIrq_o[0] !== 1'b1) begin
      $display("FAIL periodic_reset got %b want 1", TimerIrq_o[0]); errors++;
    end
    // disable while VALUE=2; the commit edge still ticks it to 1, then it freezes
    bus_write(32'h00, 32'h4);
    for (int i = 0; i < 2; i++) begin
      bus_read(32'h08, rd);
      checks++;
      if (rd !== 32'd1) begin
        $display("FAIL frozen_value[%0d] got %0d want 1", i, rd); errors++;
      end
    end
    bus_write(32'h00, 32'h0);
    bus_read(32'h0C, rd);
    checks++;
    if (rd !== 32'h1 || TimerIrq_o[0] !== 1'b0) begin
      $display("FAIL ie_mask got int=%h irq=%b want int=1 irq=0", rd, TimerIrq_o[0]); errors++;
    end
    bus_write(32'h0C, 32'h1);
    bus_read(32'h0C, rd);
    checks++;
    if (rd !== 32'h0) begin
      $display("FAIL int_w1c got %h want 0", rd); errors++;
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    logic [31:0] exp_v [4] = '{32'd2, 32'd1, 32'd0, 32'd0};
    bus_write(32'h14, 32'd2);
    bus_write(32'h10, 32'h7);
    for (int i = 0; i < 4; i++) begin
      bus_read(32'h18, rd);
      checks++;
      if (rd !== exp_v[i]) begin
        $display("FAIL oneshot_value[%0d] got %0d want %0d", i, rd, exp_v[i]); errors++;
      end
    end
    bus_read(32'h10, rd);
    checks++;
    if (rd !== 32'h6) begin
      $display("FAIL oneshot_ctrl got %h want 6", rd); errors++;
    end
    bus_read(32'h1C, rd);
    checks++;
    if (rd !== 32'h1 || TimerIrq_o[1] !== 1'b1) begin
      $display("FAIL oneshot_int got int=%h irq=%b want int=1 irq=1", rd, TimerIrq_o[1]); errors++;
    end
    // re-arm with VALUE already 0: fires on the first tick after the enable
    bus_write(32'h1C, 32'h1);
    bus_write(32'h10, 32'h7);
    bus_read(32'h1C, rd);
    checks++;
    if (rd !== 32'h0) begin
      $display("FAIL rearm_before got %h want 0", rd); errors++;
    end
    bus_read(32'h1C, rd);
    checks++;
    if (rd !== 32'h1) begin
      $display("FAIL rearm_fire got %h want 1", rd); errors++;
    end
    bus_read(32'h10, rd);
    checks++;
    if (rd !== 32'h6) begin
      $display("FAIL rearm_ctrl got %h want 6", rd); errors++;
    end
    bus_write(32'h1C, 32'h1);
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    bus_write(32'h04, 32'd0);
    bus_write(32'h00, 32'h1);
    bus_write(32'h0C, 32'h1);
    bus_read(32'h0C, rd);
    checks++;
    if (rd !== 32'h1) begin
      $display("FAIL clr_set_collision got %h want 1", rd); errors++;
    end
    bus_read(32'h08, rd);
    checks++;
    if (rd !== 32'h0) begin
      $display("FAIL load0_value got %h want 0", rd); errors++;
    end
    bus_write(32'h00, 32'h0);
    bus_write(32'h0C, 32'h1);
    bus_read(32'h0C, rd);
    checks++;
    if (rd !== 32'h0) begin
      $display("FAIL stopped_clear got %h want 0", rd); errors++;
    end
  endtask

  task automatic test_decode();
    logic [31:0] rd;
    logic [31:0] addrs [3] = '{32'h08, 32'h20, 32'h3C};
    for (int i = 0; i < 3; i++) bus_write(addrs[i], 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      bus_read(addrs[i], rd);
      checks++;
      if (rd !== 32'h0) begin
        $display("FAIL decode addr=%h got %h want 00000000", addrs[i], rd); errors++;
      end
    end
    bus_write(32'h14, 32'h1234);
    bus_read(32'h14, rd);
    checks++;
    if (rd !== 32'h1234) begin
      $display("FAIL back_to_back_load got %h want 00001234", rd); errors++;
    end
    bus_read(32'h18, rd);
    checks++;
    if (rd !== 32'h1234) begin
      $display("FAIL load_to_value got %h want 00001234", rd); errors++;
    end
  endtask

  task automatic test_prescaler();
    logic [31:0] rd;
`ifdef TIMER_PRESCALER_EN
    int n;
    bus_write(32'h100, 32'd4);
    bus_read(32'h100, rd);
    checks++;
    if (rd !== 32'd4) begin
      $display("FAIL psc_readback got %h want 4", rd); errors++;
    end
    bus_write(32'h04, 32'd1);
    bus_write(32'h00, 32'h5);
    n = 0;
    while (TimerIrq_o[0] !== 1'b1 && n < 40) begin
      @(posedge HCLK); #1; n++;
    end
    checks++;
    if (TimerIrq_o[0] !== 1'b1) begin
      $display("FAIL psc_first_irq got %b want 1 within 40 cycles", TimerIrq_o[0]); errors++;
    end
    bus_write(32'h0C, 32'h1);
    n = 1;
    do begin
      @(posedge HCLK); #1; n++;
    end while (TimerIrq_o[0] !== 1'b1 && n < 40);
    checks++;
    if (n != 10) begin
      $display("FAIL psc_period got %0d want 10", n); errors++;
    end
    bus_write(32'h00, 32'h0);
    bus_write(32'h0C, 32'h1);
`else
    bus_write(32'h100, 32'hFFFF_FFFF);
    bus_read(32'h100, rd);
    checks++;
    if (rd !== 32'h0) begin
      $display("FAIL psc_absent got %h want 00000000", rd); errors++;
    end
`endif
  endtask

  task automatic test_reset_midcount();
    logic [31:0] rd;
    logic [31:0] a;
    bus_write(32'h04, 32'd100);
    bus_write(32'h00, 32'h5);
    bus_write(32'h14, 32'd0);
    bus_write(32'h10, 32'h5);
    repeat (3) @(posedge HCLK);
    #1;
    checks++;
    if (TimerIrq_o[1] !== 1'b1) begin
      $display("FAIL midcount_pre_irq got %b want 1", TimerIrq_o[1]); errors++;
    end
    test_reset();
  endtask

  initial begin
    HRESETn = 1'b0;
    HSEL    = 1'b0;
    HADDR   = '0;
    HTRANS  = 2'b00;
    HSIZE   = 3'b010;
    HPROT   = 4'b0011;
    HWRITE  = 1'b0;
    HWDATA  = '0;
    HREADY  = 1'b1;
    test_reset();
    test_periodic();
    test_oneshot();
    test_collision();
    test_decode();
    test_prescaler();
    test_reset_midcount();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahblite_timer_multi.md
Name: ahblite_timer_multi

Overview:
- AHB-lite slave peripheral providing NUM_CH independent 32-bit down-counting timers.
- Each channel has its own control, reload value, live count and sticky interrupt flag.
- Sits on the AHB-lite peripheral bus next to the other memory-mapped I/O slaves.
- Drives one level interrupt line per channel into the NVIC IRQ inputs.

Parameters:
- NUM_CH, 2, number of timer channels (1..8).
- CNT_W, 32, counter/reload width (8..32); upper HRDATA bits read 0.
- PSC_W, 16, prescaler width; only used when TIMER_PRESCALER_EN is defined.

Ports:
- HCLK  input  1  bus and timer clock
- HRESETn  input  1  reset, active-low, synchronous to HCLK
- HSEL  input  1  slave select
- HADDR  input  32  address; HADDR[8:2] decoded
- HTRANS  input  2  transfer type; HTRANS[1] marks an active transfer
- HSIZE  input  3  ignored; every write is treated as a 32-bit word write
- HPROT  input  4  ignored
- HWRITE  input  1  write strobe
- HWDATA  input  32  write data (data phase)
- HREADY  input  1  bus ready
- HREADYOUT  output  1  constant 1; no wait states
- HRDATA  output  32  read data (data phase)
- HRESP  output  2  constant 0 (OKAY)
- TimerIrq_o  output  NUM_CH  per-channel interrupt, level, active-high

Behaviour:
- Reset: asserted when HRESETn is low at a HCLK edge. Clears all CTRL, LOAD, VALUE, INT flags, the prescaler and the pipeline registers. TimerIrq_o=0 and HRDATA=0 after reset. Reset applied mid-count aborts the count; no interrupt is generated.
- Transfer qualification: trans_en = HSEL & HTRANS[1] & HREADY.
  - Address phase: HADDR[8:2] and HWRITE are registered.
  - Data phase: writes apply HWDATA at the end of the data phase, one cycle after the address phase.
- Read path: HRDATA is combinational from the registered address and the current register contents.
  - A read in the cycle after a write to the same register returns the new value.
  - VALUE reads return the count as of that cycle.
- Register map: channel n base = n*0x10.
  - 0x0 CTRL RW: bit0 EN, bit1 ONESHOT, bit2 IE.
  - 0x4 LOAD RW.
  - 0x8 VALUE RO; writes ignored.
  - 0xC INT: read bit0 = raw flag; write 1 to bit0 clears it.
  - 0x100 PSC: see Optional Feature.
  - Unmapped offsets, and channels >= NUM_CH, read 0 and ignore writes.
- Writing LOAD also loads VALUE in the same cycle, overriding any tick in that cycle.
- Tick: asserted every HCLK without the prescaler; with the prescaler, see Optional Feature.
- Counting: applies on a tick while EN=1.
  - VALUE>0: VALUE decrements by 1.
  - VALUE==0: INT flag is set, then:
    - ONESHOT=0: VALUE reloads from LOAD.
    - ONESHOT=1: EN clears by hardware and VALUE stays 0.
  - LOAD=0 with periodic mode: the flag sets on every tick.
- Enabling: setting EN with VALUE already at 0 in one-shot mode fires on the first tick after the write.
- Disabling: clearing EN freezes VALUE; re-enabling resumes from the frozen value.
- Interrupt: TimerIrq_o[n] = INT[n] & IE[n], registered-flag based with no extra latency. If a write-1-clear and a new set occur in the same cycle, set wins. Clearing IE masks the output but keeps the flag.
- Simultaneous CTRL write (clearing EN) and a terminal tick: the bus write wins for EN, but the INT flag still sets.
- Counter width: arithmetic is CNT_W wide; LOAD/VALUE write bits above CNT_W are dropped.

Optional Feature:
- Macro: TIMER_PRESCALER_EN.
- Defined:
  - PSC register at 0x100, RW, PSC_W bits, reset 0.
  - A shared prescaler counter runs from 0 to PSC and asserts tick on wrap, so the period is PSC+1 HCLK cycles.
  - Writing PSC restarts the prescaler counter at 0.
  - The prescaler runs only while at least one channel has EN=1.
- Undefined: tick is constant 1; 0x100 reads 0 and ignores writes.

Decomposition:
- Package timer_multi_pkg holds:
  - register offset constants (CTRL/LOAD/VALUE/INT/PSC);
  - CTRL bit-index constants;
  - channel stride 0x10.
- Sub-module timer_channel, instantiated NUM_CH times. It contains EN/ONESHOT/IE, LOAD, VALUE and the INT flag. Its inputs are tick, per-register write strobes, wdata and int-clear; its outputs are register readback and irq.
- The top level holds the AHB pipeline, address decode, read mux and prescaler.

Test Plan:
- Reset: hold HRESETn=0 for 2 cycles mid-count -> every register reads 0 and TimerIrq_o=0 at the first cycle after release.
- Periodic: ch0 LOAD=3, CTRL=0x5 -> VALUE reads 3,2,1,0,3,… and INT sets every 4 cycles; TimerIrq_o[0]=1 until INT is written with 1.
- One-shot: ch1 LOAD=2, CTRL=0x7 -> INT sets after 3 ticks; CTRL then reads 0x6 (EN cleared) and VALUE stays 0.
- Clear/set collision: write INT=1 in the same cycle as a terminal tick with LOAD=0 -> the flag remains 1.
- Decode: write 0xFFFFFFFF to 0x08, 0x20 (NUM_CH=2) and 0x3C -> all read back 0; back-to-back write then read of LOAD=0x1234 returns 0x1234.
- TIMER_PRESCALER_EN: PSC=4, LOAD=1, periodic mode -> INT period is 10 HCLK; without the macro, a read of 0x100 returns 0.
